// File: rtl/mem_load_ctrl_pkg.sv
// Shared definitions for the boot-time memory loader.
//   state_e      : loader FSM states
//   target_e     : which memory a load is aimed at
//   BYTE_W, WORD_W, BYTES_PER_WORD, BYTE_IDX_W : stream/word geometry
package mem_load_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef enum logic {
    TGT_IMEM = 1'b0,
    TGT_DMEM = 1'b1
  } target_e;

endpackage

// File: rtl/mem_load_ctrl_if.sv
// Byte-stream handshake between a stream source (e.g. a UART receiver)
// and the loader.
//   byte_valid : source has a byte on byte_data
//   byte_data  : stream byte
//   byte_ready : loader takes the byte this cycle
// A byte transfers on a rising edge where byte_valid && byte_ready.
interface mem_load_ctrl_if;
  import mem_load_pkg::*;

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );

endinterface

// File: rtl/mem_load_ctrl_byte_packer.sv
// Packs a byte stream little-endian into one 32-bit word.
//   clk, rst_n : clock and synchronous active-low reset
//   clear      : discard the partial/complete word and restart at byte 0
//   accept     : byte_in is taken this cycle
//   byte_in    : stream byte
//   word       : assembled word (registered)
//   word_full  : this cycle's accept supplies the last byte of the word
module byte_packer
  import mem_load_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [BYTE_IDX_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0]     word_q, word_d;

  // Clear beats accept so an aborted final byte never completes a word.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (accept) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (cnt_q == BYTE_IDX_W'(k)) begin
          word_d[BYTE_W*k +: BYTE_W] = byte_in;
        end
      end
      cnt_d = cnt_q + BYTE_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word      = word_q;
  assign word_full = accept && !clear && (cnt_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_load_ctrl.sv
// Boot-time loader/arbiter sitting between the CPU and its two memories.
// Packs a byte stream into words, writes them to inst_mem or data_mem while
// holding the CPU in reset, then releases the CPU. When idle, the CPU's
// data-memory port passes straight through to data_mem.
//   clk, rst_n          : clock, synchronous active-low reset
//   start/target/base_addr/word_cnt : load request (sampled when idle)
//   abort               : end a load early
//   byte_if (slave)     : byte-stream handshake
//   busy, done          : status (done pulses on entering RELEASE)
//   cpu_rst_n           : reset to the CPU
//   cpu_dram_*          : CPU data-memory port
//   dmem_*, imem_*      : memory write ports
module mem_load_ctrl
  import mem_load_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int CNT_W       = 15,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              target,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  input  logic              abort,
  mem_load_ctrl_if.slave    byte_if,
  output logic              busy,
  output logic              done,
  output logic              cpu_rst_n,
  input  logic              cpu_dram_we,
  input  logic [ADDR_W-1:0] cpu_dram_a,
  input  logic [WORD_W-1:0] cpu_dram_d,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_a,
  output logic [WORD_W-1:0] dmem_d,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_a,
  output logic [WORD_W-1:0] imem_d
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e            state_q, state_d;
  target_e           tgt_q, tgt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d, idx_inc;
  logic [HC_W-1:0]   rel_cnt_q, rel_cnt_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              byte_ready_q, byte_ready_d;
  logic              imem_we_q, imem_we_d;
  logic              dmem_wr_q, dmem_wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic              accept;
  logic              pk_clear;
  logic              pk_word_full;
  logic [WORD_W-1:0] pk_word;

  assign accept = byte_if.byte_valid && byte_ready_q;

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .accept    (accept),
    .byte_in   (byte_if.byte_data),
    .word      (pk_word),
    .word_full (pk_word_full)
  );

  // Next-state logic. Write strobes and address are computed on the edge
  // that accepts the last byte, so in WRITE they come straight from flops
  // and stay stable across the negedge-clocked memories.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rel_cnt_d = rel_cnt_q;
    done_d    = 1'b0;
    imem_we_d = 1'b0;
    dmem_wr_d = 1'b0;
    wr_addr_d = wr_addr_q;
    pk_clear  = 1'b0;
    idx_inc   = idx_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d  = target_e'(target);
          base_d = base_addr;
          cnt_d  = word_cnt;
          idx_d  = '0;
          if (word_cnt == '0) begin
            state_d   = RELEASE;
            done_d    = 1'b1;
            rel_cnt_d = '0;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        // Abort wins over a completing byte; the partial word is dropped.
        if (abort) begin
          pk_clear  = 1'b1;
          state_d   = RELEASE;
          done_d    = 1'b1;
          rel_cnt_d = '0;
        end else if (pk_word_full) begin
          state_d   = WRITE;
          imem_we_d = (tgt_q == TGT_IMEM);
          dmem_wr_d = (tgt_q == TGT_DMEM);
          // Truncation to ADDR_W gives the intended address wrap.
          wr_addr_d = base_q + idx_q[ADDR_W-1:0];
        end
      end

      WRITE: begin
        // The write in flight always completes; abort only stops the next.
        pk_clear = 1'b1;
        idx_d    = idx_inc;
        if (abort || (idx_inc == cnt_q)) begin
          state_d   = RELEASE;
          done_d    = 1'b1;
          rel_cnt_d = '0;
        end else begin
          state_d = LOAD;
        end
      end

      RELEASE: begin
        if (rel_cnt_q == HC_W'(HOLD_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          rel_cnt_d = rel_cnt_q + HC_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    byte_ready_d = (state_d == LOAD);
    busy_d       = (state_d != IDLE);
    hold_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tgt_q        <= TGT_IMEM;
      base_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      rel_cnt_q    <= '0;
      hold_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      dmem_wr_q    <= 1'b0;
      wr_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rel_cnt_q    <= rel_cnt_d;
      hold_q       <= hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      dmem_wr_q    <= dmem_wr_d;
      wr_addr_q    <= wr_addr_d;
    end
  end

  assign byte_if.byte_ready = byte_ready_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign cpu_rst_n          = rst_n & ~hold_q;

  assign imem_we = imem_we_q;
  assign imem_a  = wr_addr_q;
  assign imem_d  = pk_word;

  // While busy the CPU port is cut off; only loader writes reach data_mem.
  assign dmem_we = busy_q ? dmem_wr_q : cpu_dram_we;
  assign dmem_a  = busy_q ? wr_addr_q : cpu_dram_a;
  assign dmem_d  = busy_q ? pk_word   : cpu_dram_d;

endmodule
